guess_game_ctrl: RTL and testbench

//  Game sequencer for the guess-the-number datapath. Latches the secret from the LFSR on start,

---
 rtl/guess_pkg.sv | 20 ++
 rtl/sec_countdown.sv | 43 ++++
 rtl/guess_game_ctrl.sv | 136 +++++++++++++
 tb/tb_guess_game_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types and default sizing for the guess-the-number game sequencer.
`timescale 1ns/1ps
package guess_pkg;

    localparam int NUM_W         = 4;
    localparam int LIVES_INIT    = 3;
    localparam int LIVES_W       = 2;
    localparam int TICKS_PER_SEC = 100000000;
    localparam int GUESS_SECS    = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        PLAY  = 3'd2,
        JUDGE = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

endpackage

// File: rtl/sec_countdown.sv
// Per-guess countdown: a prescaler dividing clk down to seconds feeding a 4-bit
// saturating down-counter; reload has priority over counting.
`timescale 1ns/1ps
module sec_countdown #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int GUESS_SECS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       reload,
    output logic [3:0] secs_left,
    output logic       timeout
);

    localparam int              PRE_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]      SECS_INIT = 4'(GUESS_SECS);

    logic [PRE_W-1:0] prescaler;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            secs_left <= SECS_INIT;
        end else if (reload) begin
            prescaler <= '0;
            secs_left <= SECS_INIT;
        end else if (en) begin
            if (prescaler == PRE_MAX) begin
                prescaler <= '0;
                if (secs_left != 4'd0)
                    secs_left <= secs_left - 4'd1;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    assign timeout = (secs_left == 4'd0);

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-the-number game sequencer: secret capture, countdown, judging and lives.
// Optional REPEAT_FORGIVE_EN: repeated wrong guesses cost no life and keep the timer running.
`timescale 1ns/1ps
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int NUM_W         = guess_pkg::NUM_W,
    parameter int LIVES_INIT    = guess_pkg::LIVES_INIT,
    parameter int LIVES_W       = guess_pkg::LIVES_W,
    parameter int TICKS_PER_SEC = guess_pkg::TICKS_PER_SEC,
    parameter int GUESS_SECS    = guess_pkg::GUESS_SECS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               guess_valid,
    input  logic [NUM_W-1:0]   gnum,
    input  logic [NUM_W-1:0]   rnd,
    output logic               low,
    output logic               high,
    output logic               bingo,
    output logic [LIVES_W-1:0] lives,
    output logic [3:0]         secs_left,
    output logic               playing,
    output logic               game_over,
    output logic               win
);

    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);

    state_t             state;
    logic [NUM_W-1:0]   secret;
    logic [NUM_W-1:0]   guess_q;
    logic               timed_out;
    logic               timeout;
    logic               timer_reload;
    logic               guess_hit;
    logic               repeat_hit;
    logic               charge;
    logic [LIVES_W-1:0] lives_next;

    sec_countdown #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .GUESS_SECS    (GUESS_SECS)
    ) u_countdown (
        .clk       (clk),
        .reset     (reset),
        .en        (state == PLAY),
        .reload    (timer_reload),
        .secs_left (secs_left),
        .timeout   (timeout)
    );

`ifdef REPEAT_FORGIVE_EN
    logic [2**NUM_W-1:0] tried;
    assign repeat_hit = !timed_out && tried[guess_q];
`else
    assign repeat_hit = 1'b0;
`endif

    // A judged timeout always costs a life; a wrong guess does unless it is a forgiven repeat.
    assign guess_hit    = !timed_out && (guess_q == secret);
    assign charge       = timed_out || (!guess_hit && !repeat_hit);
    assign lives_next   = !charge ? lives : (lives == '0) ? '0 : lives - LIVES_W'(1);
    assign timer_reload = (state == ARM) || ((state == JUDGE) && charge);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            secret    <= '0;
            guess_q   <= '0;
            timed_out <= 1'b0;
            lives     <= LIVES_START;
            low       <= 1'b0;
            high      <= 1'b0;
            bingo     <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start)
                        state <= ARM;
                end
                ARM: begin
                    secret <= rnd;
                    lives  <= LIVES_START;
                    low    <= 1'b0;
                    high   <= 1'b0;
                    bingo  <= 1'b0;
                    state  <= PLAY;
                end
                PLAY: begin
                    // A guess arriving on the timeout cycle wins over the timeout.
                    if (guess_valid) begin
                        guess_q   <= gnum;
                        timed_out <= 1'b0;
                        state     <= JUDGE;
                    end else if (timeout) begin
                        timed_out <= 1'b1;
                        state     <= JUDGE;
                    end
                end
                JUDGE: begin
                    if (guess_hit) begin
                        bingo <= 1'b1;
                        low   <= 1'b0;
                        high  <= 1'b0;
                        state <= WIN;
                    end else begin
                        low   <= !timed_out && (guess_q < secret);
                        high  <= !timed_out && (guess_q > secret);
                        lives <= lives_next;
                        state <= (lives_next == '0) ? LOSE : PLAY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REPEAT_FORGIVE_EN
    // NOTE: the tried mask is plain flops, so it takes the async reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tried <= '0;
        else if (state == ARM)
            tried <= '0;
        else if ((state == JUDGE) && !timed_out && !guess_hit)
            tried[guess_q] <= 1'b1;
    end
`endif

    assign playing   = (state == PLAY);
    assign win       = (state == WIN);
    assign game_over = (state == WIN) || (state == LOSE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl: directed scenarios plus randomized play
// compared every cycle against a game-level model built on elapsed play time.
`timescale 1ns/1ps
module tb_guess_game_ctrl;

    localparam int TPS   = 4;
    localparam int SECS  = 10;
    localparam int LIVES = 3;
    localparam int LIMIT = TPS * SECS;
`ifdef REPEAT_FORGIVE_EN
    localparam bit FORGIVE = 1'b1;
`else
    localparam bit FORGIVE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [3:0] gnum = 4'd0;
    logic [3:0] rnd = 4'd0;
    logic       low, high, bingo, playing, game_over, win;
    logic [1:0] lives;
    logic [3:0] secs_left;

    int errors = 0;
    int checks = 0;
    bit compare_en = 1'b0;

    guess_game_ctrl #(
        .NUM_W         (4),
        .LIVES_INIT    (LIVES),
        .LIVES_W       (2),
        .TICKS_PER_SEC (TPS),
        .GUESS_SECS    (SECS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .guess_valid (guess_valid),
        .gnum        (gnum),
        .rnd         (rnd),
        .low         (low),
        .high        (high),
        .bingo       (bingo),
        .lives       (lives),
        .secs_left   (secs_left),
        .playing     (playing),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: time spent guessing is tracked as elapsed play cycles.
    typedef enum {P_WAITSTART, P_LOADING, P_GUESSING, P_SCORING, P_WON, P_LOST} phase_t;
    phase_t m_phase;
    int     m_secret, m_lives, m_elapsed, m_guess;
    bit     m_to, m_low, m_high, m_bingo;
    bit     m_tried [16];

    function automatic int m_secs();
        return (m_elapsed >= LIMIT) ? 0 : SECS - m_elapsed / TPS;
    endfunction

    task automatic model_reset();
        m_phase   = P_WAITSTART;
        m_secret  = 0;
        m_lives   = LIVES;
        m_elapsed = 0;
        m_guess   = 0;
        m_to      = 1'b0;
        m_low     = 1'b0;
        m_high    = 1'b0;
        m_bingo   = 1'b0;
        foreach (m_tried[i]) m_tried[i] = 1'b0;
    endtask

    task automatic model_step();
        bit free;
        case (m_phase)
            P_WAITSTART, P_WON, P_LOST: if (start) m_phase = P_LOADING;
            P_LOADING: begin
                m_secret  = int'(rnd);
                m_lives   = LIVES;
                m_low     = 1'b0;
                m_high    = 1'b0;
                m_bingo   = 1'b0;
                m_elapsed = 0;
                foreach (m_tried[i]) m_tried[i] = 1'b0;
                m_phase   = P_GUESSING;
            end
            P_GUESSING: begin
                if (guess_valid) begin
                    m_guess = int'(gnum);
                    m_to    = 1'b0;
                    m_phase = P_SCORING;
                end else if (m_elapsed >= LIMIT) begin
                    m_to    = 1'b1;
                    m_phase = P_SCORING;
                end
                if (m_elapsed < 1000) m_elapsed++;
            end
            P_SCORING: begin
                if (!m_to && m_guess == m_secret) begin
                    m_bingo = 1'b1;
                    m_low   = 1'b0;
                    m_high  = 1'b0;
                    m_phase = P_WON;
                end else begin
                    free   = !m_to && FORGIVE && m_tried[m_guess];
                    m_low  = !m_to && (m_guess < m_secret);
                    m_high = !m_to && (m_guess > m_secret);
                    if (!free) begin
                        if (m_lives > 0) m_lives--;
                        m_elapsed = 0;
                        if (!m_to) m_tried[m_guess] = 1'b1;
                    end
                    m_phase = (m_lives == 0) ? P_LOST : P_GUESSING;
                end
            end
            default: m_phase = P_WAITSTART;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (compare_en && reset === 1'b1) begin
                check("cyc_low",       low,       m_low);
                check("cyc_high",      high,      m_high);
                check("cyc_bingo",     bingo,     m_bingo);
                check("cyc_lives",     lives,     m_lives);
                check("cyc_secs",      secs_left, m_secs());
                check("cyc_playing",   playing,   m_phase == P_GUESSING);
                check("cyc_game_over", game_over, m_phase == P_WON || m_phase == P_LOST);
                check("cyc_win",       win,       m_phase == P_WON);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        #2;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic do_start(input logic [3:0] r);
        @(negedge clk);
        start = 1'b1;
        rnd   = r;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Called on a falling edge while playing; returns once the judgement is visible.
    task automatic do_guess(input logic [3:0] g);
        guess_valid = 1'b1;
        gnum        = g;
        @(negedge clk);
        guess_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_lives",   lives,     3);
        check("rst_secs",    secs_left, 10);
        check("rst_playing", playing,   0);
        check("rst_over",    game_over, 0);
        apply_reset();
        compare_en = 1'b1;

        // Immediate win.
        do_start(4'd7);
        do_guess(4'd7);
        check("t1_bingo", bingo,     1);
        check("t1_win",   win,       1);
        check("t1_over",  game_over, 1);
        check("t1_lives", lives,     3);

        // Three wrong guesses lose the game.
        do_start(4'd7);
        do_guess(4'd9);
        check("t2_high1",  high,  1);
        check("t2_lives1", lives, 2);
        do_guess(4'd2);
        check("t2_low2",   low,   1);
        check("t2_lives2", lives, 1);
        do_guess(4'd12);
        check("t2_high3",  high,      1);
        check("t2_lives3", lives,     0);
        check("t2_over",   game_over, 1);
        check("t2_win",    win,       0);
        check("t2_model_lives", m_lives, 0);

        // Countdown expiry costs a life and reloads the timer.
        do_start(4'd5);
        check("t3_secs10", secs_left, 10);
        repeat (4) @(negedge clk);
        check("t3_secs9", secs_left, 9);
        repeat (36) @(negedge clk);
        check("t3_secs0", secs_left, 0);
        check("t3_play0", playing,   1);
        @(negedge clk);
        check("t3_judging", playing, 0);
        @(negedge clk);
        check("t3_lives",  lives,     2);
        check("t3_reload", secs_left, 10);
        check("t3_play1",  playing,   1);
        check("t3_model_secs", m_secs(), 10);

        // Guess on the timeout cycle beats the timeout.
        apply_reset();
        do_start(4'd5);
        repeat (40) @(negedge clk);
        check("t4_secs0", secs_left, 0);
        do_guess(4'd5);
        check("t4_bingo", bingo, 1);
        check("t4_win",   win,   1);
        check("t4_lives", lives, 3);

        // Start ignored mid-game; async reset mid-game.
        do_start(4'd7);
        do_guess(4'd9);
        do_guess(4'd2);
        check("t5_lives1", lives, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_still_play",  playing, 1);
        check("t5_still_lives", lives,   1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_lives", lives,     3);
        check("t5_rst_play",  playing,   0);
        check("t5_rst_over",  game_over, 0);
        check("t5_rst_low",   low,       0);
        check("t5_rst_high",  high,      0);
        check("t5_rst_secs",  secs_left, 10);
        @(negedge clk);
        #1 reset = 1'b1;

        // Repeated wrong guess.
        do_start(4'd7);
        do_guess(4'd9);
        check("t6_high1",  high,  1);
        check("t6_lives1", lives, 2);
        do_guess(4'd9);
        check("t6_high2",  high,  1);
        check("t6_lives2", lives, FORGIVE ? 2 : 1);

        // Randomized play, alternating busy and sluggish players.
        apply_reset();
        for (int blk = 0; blk < 8; blk++) begin
            for (int cyc = 0; cyc < 500; cyc++) begin
                @(negedge clk);
                rnd         = 4'($urandom);
                start       = ($urandom % 12) == 0;
                guess_valid = (blk % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 60) == 0);
                gnum        = (blk % 4 < 2) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 9));
                if (($urandom % 600) == 0) begin
                    #1 reset = 1'b0;
                    #2 reset = 1'b1;
                end
            end
        end

        @(negedge clk);
        start       = 1'b0;
        guess_valid = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
